// File: rtl/checksum_frame_ctrl_pkg.sv
// Shared types and constants for the Fletcher-style checksum framer.
package checksum_frame_ctrl_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int unsigned MODULUS = (1 << DEF_WORD_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EMIT_A  = 2'd2,
    EMIT_B  = 2'd3
  } state_e;

endpackage

// File: rtl/checksum_frame_ctrl_if.sv
// Payload input stream and framed output stream of checksum_frame_ctrl.
interface checksum_frame_ctrl_if #(
  parameter int WordWidth = checksum_frame_ctrl_pkg::DEF_WORD_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WordWidth-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WordWidth-1:0] out_data;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/checksum_frame_ctrl_fletcher_accum.sv
// Running A/B sums modulo 2^WordWidth-1 using end-around carry addition.
module fletcher_accum #(
  parameter int WordWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [WordWidth-1:0] din,
  output logic [WordWidth-1:0] a,
  output logic [WordWidth-1:0] b
);

  // Carry folds back into bit 0; the result can never overflow again.
  function automatic logic [WordWidth-1:0] add1c(input logic [WordWidth-1:0] x,
                                                 input logic [WordWidth-1:0] y);
    logic [WordWidth:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[WordWidth-1:0] + {{(WordWidth-1){1'b0}}, s[WordWidth]};
  endfunction

  logic [WordWidth-1:0] a_next;
  logic [WordWidth-1:0] b_next;

  assign a_next = add1c(a, din);
  assign b_next = add1c(b, a_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (clear) begin
      a <= '0;
      b <= '0;
    end else if (en) begin
      a <= a_next;
      b <= b_next;
    end
  end

endmodule

// File: rtl/checksum_frame_ctrl.sv
// Frames a payload stream and appends Fletcher A/B checksum words.
// Optional receive-side verification via CHECKSUM_FRAME_CTRL_VERIFY_EN.
//  state   | meaning
//  IDLE    | waiting for start
//  PAYLOAD | forwarding len payload words, accumulating A/B
//  EMIT_A  | presenting A (verify: consuming received A)
//  EMIT_B  | presenting B with last (verify: consuming received B)
module checksum_frame_ctrl
  import checksum_frame_ctrl_pkg::*;
#(
  parameter int WordWidth = DEF_WORD_WIDTH,
  parameter int LenWidth  = DEF_LEN_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LenWidth-1:0] len,
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
  input  logic                verify,
  output logic                match,
  output logic                match_valid,
`endif
  checksum_frame_ctrl_if.slave bus,
  output logic                busy,
  output logic                done
);

  localparam logic [LenWidth-1:0]  CountOne = LenWidth'(1);
  localparam logic [WordWidth-1:0] AllOnes  = '1;

  state_e               state_q, state_d;
  logic [LenWidth-1:0]  count_q, count_d;
  logic [WordWidth-1:0] pay_data_q, pay_data_d;
  logic                 pay_valid_q, pay_valid_d;
  logic                 done_q, done_d;
  logic                 acc_clear, acc_en;
  logic [WordWidth-1:0] acc_a, acc_b, sum_a, sum_b;
  logic                 in_ready_c, out_valid_c, out_last_c;
  logic [WordWidth-1:0] out_data_c;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
  logic verify_q, verify_d, pay_last_q, pay_last_d;
  logic rx_a_ok_q, rx_a_ok_d, match_q, match_d, match_valid_q, match_valid_d;
`endif

  fletcher_accum #(.WordWidth(WordWidth)) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .en    (acc_en),
    .din   (bus.in_data),
    .a     (acc_a),
    .b     (acc_b)
  );

  // All-ones is the second encoding of zero in ones-complement arithmetic.
  assign sum_a = (acc_a == AllOnes) ? '0 : acc_a;
  assign sum_b = (acc_b == AllOnes) ? '0 : acc_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
      verify_q      <= 1'b0;
      pay_last_q    <= 1'b0;
      rx_a_ok_q     <= 1'b0;
      match_q       <= 1'b0;
      match_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      done_q      <= done_d;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
      verify_q      <= verify_d;
      pay_last_q    <= pay_last_d;
      rx_a_ok_q     <= rx_a_ok_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pay_data_d  = pay_data_q;
    pay_valid_d = pay_valid_q && !bus.out_ready;
    done_d      = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = pay_valid_q;
    out_data_c  = pay_data_q;
    out_last_c  = 1'b0;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    verify_d      = verify_q;
    pay_last_d    = pay_last_q;
    rx_a_ok_d     = rx_a_ok_q;
    match_d       = match_q;
    match_valid_d = 1'b0;
    out_last_c    = pay_valid_q && pay_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          count_d   = len;
          state_d   = (len == '0) ? EMIT_A : PAYLOAD;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
          verify_d  = verify;
`endif
        end
      end
      PAYLOAD: begin
        in_ready_c = !pay_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready_c) begin
          acc_en      = 1'b1;
          pay_data_d  = bus.in_data;
          pay_valid_d = 1'b1;
          count_d     = count_q - CountOne;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
          pay_last_d  = verify_q && (count_q == CountOne);
`endif
          if (count_q == CountOne) state_d = EMIT_A;
        end
      end
      // Checksum words wait until the final payload word has drained.
      EMIT_A: begin
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
        if (verify_q) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            rx_a_ok_d = (bus.in_data == sum_a);
            state_d   = EMIT_B;
          end
        end else
`endif
        if (!pay_valid_q) begin
          out_valid_c = 1'b1;
          out_data_c  = sum_a;
          if (bus.out_ready) state_d = EMIT_B;
        end
      end
      EMIT_B: begin
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
        if (verify_q) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            match_d       = rx_a_ok_q && (bus.in_data == sum_b);
            match_valid_d = 1'b1;
            done_d        = 1'b1;
            state_d       = IDLE;
          end
        end else
`endif
        if (!pay_valid_q) begin
          out_valid_c = 1'b1;
          out_data_c  = sum_b;
          out_last_c  = 1'b1;
          if (bus.out_ready) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
  assign match         = match_q;
  assign match_valid   = match_valid_q;
`endif

endmodule

// File: tb/tb_checksum_frame_ctrl.sv
// Self-checking bench for checksum_frame_ctrl against a modular-arithmetic model.
module tb_checksum_frame_ctrl;
  import checksum_frame_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
  logic        verify;
  logic        match;
  logic        match_valid;
`endif

  checksum_frame_ctrl_if #(.WordWidth(16)) bus ();

  checksum_frame_ctrl #(.WordWidth(16), .LenWidth(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    .verify      (verify),
    .match       (match),
    .match_valid (match_valid),
`endif
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] pay_q[$];
  logic [16:0] exp_q[$];
  bit          exp_match;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input bit last, input logic [15:0] d);
    exp_q.push_back({last, d});
  endtask

  // Reference: A/B as plain sums modulo 2^16-1 (mod result never equals 0xFFFF).
  task automatic build_expect(input int n, input bit vfy);
    int unsigned a, b;
    a = 0;
    b = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = (a + pay_q[i]) % MODULUS;
      b = (b + a) % MODULUS;
      push_exp(vfy && (i == n - 1), pay_q[i]);
    end
    if (vfy) exp_match = (pay_q[n] == a[15:0]) && (pay_q[n+1] == b[15:0]);
    else begin
      push_exp(1'b0, a[15:0]);
      push_exp(1'b1, b[15:0]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    chk({tag, "_match_valid"}, match_valid, 0);
`endif
  endtask

  // mode: 0 = out_ready always 1, 1 = toggle each cycle, 2 = random
  task automatic run_frame(input string tag, input int n, input bit vfy, input int mode,
                           input bit gaps, input bit poke_start);
    int          idx, cyc, total, n_done;
    bit          exp_done, prev_stall, done_seen;
    logic [15:0] prev_data;
    logic [16:0] e;
    idx = 0; cyc = 0; n_done = 0;
    exp_done = 0; prev_stall = 0; done_seen = 0; prev_data = '0;
    total = n + (vfy ? 2 : 0);
    @(negedge clk);
    start = 1'b1;
    len = 16'(n);
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    verify = vfy;
`endif
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_idle_before_start"}, busy, 0);
    while (cyc < 2000) begin
      @(negedge clk);
      start = poke_start && (cyc == 2);
      len = 16'($urandom_range(1, 9));
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (idx < total) begin
        bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.in_data  = pay_q[idx];
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 16'($urandom);
      end
      #1;
      if (cyc == 0) begin
        chk({tag, "_busy_after_start"}, busy, 1);
        if (n == 0 && !vfy) chk({tag, "_len0_valid_now"}, bus.out_valid, 1);
      end
      chk({tag, "_done"}, done, exp_done);
      if (done) begin
        done_seen = 1;
        n_done++;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
        if (vfy) begin
          chk({tag, "_match_valid"}, match_valid, 1);
          chk({tag, "_match"}, match, exp_match);
        end
`endif
      end
      exp_done = 0;
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, bus.out_valid, 1);
        chk({tag, "_stall_data"}, bus.out_data, prev_data);
      end
      if (idx >= total) chk({tag, "_no_input_after_len"}, bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk({tag, "_extra_word"}, bus.out_data, 32'hDEAD_0000);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, bus.out_data, e[15:0]);
          chk({tag, "_last"}, bus.out_last, e[16]);
          if (e[16] && !vfy) exp_done = 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        if (vfy && idx == total - 1) exp_done = 1;
        idx++;
      end
      cyc++;
      if (done_seen && exp_q.size() == 0 && !exp_done) break;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_no_timeout"}, cyc < 2000, 1);
    chk({tag, "_leftover_words"}, exp_q.size(), 0);
    chk({tag, "_done_count"}, n_done, 1);
    @(negedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic load_req025_payload();
    pay_q = '{16'h6261, 16'h6463, 16'h6665};
  endtask

  task automatic expect_req025();
    exp_q.delete();
    push_exp(0, 16'h6261); push_exp(0, 16'h6463); push_exp(0, 16'h6665);
    push_exp(0, 16'h2D2A); push_exp(1, 16'h5650);
  endtask

  initial begin
    int n;
    int mode;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    verify = 1'b0;
`endif
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_req025_payload(); expect_req025();
    run_frame("basic", 3, 0, 0, 0, 0);

    pay_q.delete();
    exp_q.delete(); push_exp(0, 16'h0000); push_exp(1, 16'h0000);
    run_frame("len0", 0, 0, 0, 0, 0);

    load_req025_payload(); expect_req025();
    run_frame("stall", 3, 0, 1, 1, 0);

    pay_q = '{16'hFFFF, 16'hFFFF};
    exp_q.delete();
    push_exp(0, 16'hFFFF); push_exp(0, 16'hFFFF); push_exp(0, 16'h0000); push_exp(1, 16'h0000);
    run_frame("ones_poke", 2, 0, 0, 0, 1);

    // Reset after the second payload word of a len=3 frame.
    @(negedge clk);
    start = 1'b1; len = 16'd3; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h6261;
    @(negedge clk);
    bus.in_data = 16'h6463;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    load_req025_payload(); expect_req025();
    run_frame("after_rst", 3, 0, 0, 0, 0);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 8);
      mode = $urandom_range(0, 2);
      pay_q.delete();
      for (int i = 0; i < n; i++)
        pay_q.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      build_expect(n, 0);
      run_frame("rand", n, 0, mode, 1'($urandom_range(0, 1)), 0);
    end

`ifdef CHECKSUM_FRAME_CTRL_VERIFY_EN
    pay_q = '{16'h6261, 16'h6463, 16'h6665, 16'h2D2A, 16'h5650};
    exp_q.delete();
    push_exp(0, 16'h6261); push_exp(0, 16'h6463); push_exp(1, 16'h6665);
    exp_match = 1;
    run_frame("verify_ok", 3, 1, 0, 0, 0);

    pay_q = '{16'h6261, 16'h6463, 16'h6665, 16'h2D2A, 16'h5651};
    exp_q.delete();
    push_exp(0, 16'h6261); push_exp(0, 16'h6463); push_exp(1, 16'h6665);
    exp_match = 0;
    run_frame("verify_bad", 3, 1, 1, 1, 0);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 6);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
      build_expect(n, 1'b0);
      pay_q.push_back(exp_q[n][15:0]);
      pay_q.push_back((f % 2 == 0) ? exp_q[n+1][15:0] : 16'(exp_q[n+1][15:0] ^ 16'h0001));
      build_expect(n, 1'b1);
      run_frame("verify_rand", n, 1, 2, 1, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
